// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: transmit state encoding, frame
//            constants and the bit-period helper used by TX and RX paths.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable in parity builds
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Integer cycles per bit; the remainder is simply dropped
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Brief    : Free-running bit-period counter with synchronous clear. The
//            tick output is high on the last cycle of each bit period and
//            the count wraps to zero on the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int               c_WIDTH = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(CLKS_PER_BIT - 1);

    logic [c_WIDTH-1:0] r_count;

    // Count up to the last cycle of the bit, then wrap; clear holds it at zero
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_WIDTH'(1);
        end
    end

    assign o_tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter. Accepts a byte on a valid/ready handshake and
//            serializes it LSB first as 8N1, or as 8E1 when the
//            UART_TX_PARITY_EN macro is defined (even parity bit after
//            data bit 7). All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] c_LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t r_state;
    logic [7:0]     r_shreg;
    logic [2:0]     r_bit_cnt;
    logic           r_tx;
    logic           r_tx_ready;
    logic           r_busy;
    logic           w_tick;
    logic           w_clear;
`ifdef UART_TX_PARITY_EN
    logic           r_parity;
`endif

    // Every non-idle state exits on a tick, where the counter wraps to zero,
    // so holding it clear in IDLE makes each state start from count 0.
    assign w_clear = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (sysclk),
        .rst     (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Frame sequencer; tx is registered with the value of the state being entered
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= UART_IDLE_LEVEL;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx       <= UART_IDLE_LEVEL;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    if (tx_valid && r_tx_ready) begin
                        r_shreg    <= tx_data;
                        r_bit_cnt  <= '0;
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            // Next bit is shreg[1], which becomes shreg[0] after the shift
                            r_shreg <= r_shreg >> 1;
                            r_tx    <= r_shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= UART_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state    <= IDLE;
                        r_tx       <= UART_IDLE_LEVEL;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx       <= UART_IDLE_LEVEL;
                    r_tx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one byte per valid/ready handshake and drives it onto `tx` as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) at a fixed baud rate derived from `sysclk`. It is the transmit-side counterpart of the UART receive path. It sits between on-chip logic producing response bytes (register read-back, TDC results) and the board-level serial line.

## Interface
- `CLK_FREQ`, 100000000: `sysclk` frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (integer, truncating; 10416 at defaults): cycles per bit. Must be ≥ 2.

Ports:
- `sysclk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `tx_data` in 8: byte to send; sampled only on handshake.
- `tx_valid` in 1: producer has a byte.
- `tx_ready` out 1: block can accept a byte. Registered.
- `tx` out 1: serial line, idle high. Registered, glitch-free.
- `busy` out 1: high while a frame is on the line (START through STOP).

## Operation
- Handshake: a byte is accepted on a rising edge where `tx_valid && tx_ready`. It is copied into an internal shift register. Later changes on `tx_data` have no effect on the frame in flight.
- `tx_ready` = 1 only in IDLE. `tx_valid` while not ready is ignored, so no byte is lost or duplicated. The producer holds `tx_valid` until it sees `tx_ready`.
- States:
  - IDLE: `tx`=1. On handshake, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shreg[0]. After each CLKS_PER_BIT cycles, shift right and increment the 3-bit bit counter. After bit 7 completes, go to PARITY if enabled, else STOP.
  - PARITY (optional): `tx`=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. Cleared on every state entry. The bit boundary is where the counter == CLKS_PER_BIT−1. There is no fractional-rate correction; the rate error comes only from truncation.
- Reset value of every output: `tx`=1, `tx_ready`=0, `busy`=0. State=IDLE, counters=0.
- Reset mid-frame: on the next edge `tx` returns to 1 and the partial frame is abandoned. No resume. The receiver sees a framing error, which is acceptable.

## Timing
- Latency: handshake at edge N → `tx` falls at edge N+1. `busy` and `tx_ready` update at the same edge.
- Frame length: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity), measured from the `tx` falling edge to the IDLE entry.
- `tx_ready` rises at the edge where STOP completes.
- Back-to-back frames (`tx_valid` held high): one IDLE cycle between frames. The stop bit is therefore CLKS_PER_BIT+1 cycles, giving sustained throughput of one byte per 10·CLKS_PER_BIT+1 cycles.
- `tx_ready` reaches 1 at the first edge after `reset` deasserts.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and an even-parity bit (XOR of the 8 data bits) is sent after bit 7, giving an 8E1 frame.
- Not defined: 8N1. The PARITY state and its logic are absent.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1'b1;
  - a `clks_per_bit(clk_freq, baud)` function, for reuse by the receive path.
- One sub-module: `uart_baud_cnt`, a counter with a clear input and a tick output. It is parameterized by CLKS_PER_BIT and shared with the receiver.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16) unless stated.
- Single byte 0x01: handshake at cycle 10 → `tx`=0 over cycles 11–26, 1 over 27–42, 0 over 43–154, 1 over 155–170. `tx_ready`=1 again at cycle 171. `busy` is high exactly over cycles 11–170.
- Back-to-back 0x00 then 0x04 with `tx_valid` held: the second start bit falls 161 cycles after the first. The 0x04 frame has only data bit 2 high.
- `tx_valid` pulsed with 0xFF while `busy`, then `tx_data` changed mid-frame: the line carries only the originally accepted byte and no second frame follows.
- `reset` asserted at cycle 60 (inside DATA): `tx`=1 from cycle 61. After release, `tx_ready`=1 one cycle later, and a new 0x55 frame is serialized correctly.
- `UART_TX_PARITY_EN` defined, bytes 0x03 and 0x01: parity bit 0 and 1 respectively. Each frame is 176 cycles.
- Defaults (100 MHz, 9600 baud), loopback into the UART receiver, bytes 1,0,4,1,2,3,4,2,0,4: the receiver reproduces all 10 bytes in order. Measured bit period is 104.16 µs ±0.01%.
